// File: rtl/horn_tone_gen.sv
// Enveloped square-wave tone generator for the horn/noise audio path.
// Optional PWM speaker output is built when HORN_PWM_EN is defined.
module horn_tone_gen #(
  parameter logic [14:0] AMP_MAX  = 15'h7FFF,
  parameter logic [14:0] ATK_STEP = 15'h0800,
  parameter logic [14:0] REL_STEP = 15'h0400,
  parameter int unsigned ENV_TICK = 1024
) (
  input  logic               clk_noise,
  input  logic               rst_n,
  input  logic [21:0]        note_div,
  output logic signed [15:0] sample_out,
  output logic               tone_active,
  output logic               pwm_out
);

  localparam int TW = (ENV_TICK > 1) ? $clog2(ENV_TICK) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(ENV_TICK - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_SUSTAIN,
    ST_RELEASE
  } state_t;

  function automatic logic [14:0] amp_up(input logic [14:0] a);
    logic [15:0] s;
    s = {1'b0, a} + {1'b0, ATK_STEP};
    return (s >= {1'b0, AMP_MAX}) ? AMP_MAX : s[14:0];
  endfunction

  function automatic logic [14:0] amp_dn(input logic [14:0] a);
    logic signed [15:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, REL_STEP});
    return d[15] ? 15'd0 : d[14:0];
  endfunction

  state_t             state_q, state_d;
  logic [14:0]        amp_q, amp_d;
  logic [21:0]        cur_div_q, cur_div_d;
  logic [21:0]        cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic signed [15:0] sample_q, sample_d;
  logic               tone_active_q, tone_active_d;
  logic               gate;
  logic               tick;

  assign gate = (note_div != 22'd0);
  assign tick = (tcnt_q == TICK_LAST);

  always_comb begin
    tcnt_d = tick ? '0 : tcnt_q + 1'b1;
  end

  // Divider: pitch reloads only at a half-period boundary
  always_comb begin
    cur_div_d = cur_div_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    if (state_q == ST_IDLE) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      if (gate) cur_div_d = note_div;
    end else if (cnt_q == cur_div_q - 22'd1) begin
      phase_d = ~phase_q;
      cnt_d   = '0;
      if (gate) cur_div_d = note_div;
    end else begin
      cnt_d = cnt_q + 22'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    case (state_q)
      ST_IDLE: begin
        amp_d = '0;
        if (gate) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!gate) begin
          state_d = ST_RELEASE;
        end else if (tick) begin
          amp_d = amp_up(amp_q);
          if (amp_d == AMP_MAX) state_d = ST_SUSTAIN;
        end
      end
      ST_SUSTAIN: begin
        amp_d = AMP_MAX;
        if (!gate) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Re-keying resumes the attack from the current level
        if (gate) begin
          state_d = ST_ATTACK;
        end else if (tick) begin
          amp_d = amp_dn(amp_q);
          if (amp_d == 15'd0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    logic signed [15:0] mag;
    mag           = $signed({1'b0, amp_q});
    sample_d      = phase_q ? mag : -mag;
    tone_active_d = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk_noise or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      amp_q         <= '0;
      cur_div_q     <= '0;
      cnt_q         <= '0;
      phase_q       <= 1'b0;
      tcnt_q        <= '0;
      sample_q      <= '0;
      tone_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      amp_q         <= amp_d;
      cur_div_q     <= cur_div_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      tcnt_q        <= tcnt_d;
      sample_q      <= sample_d;
      tone_active_q <= tone_active_d;
    end
  end

  assign sample_out  = sample_q;
  assign tone_active = tone_active_q;

`ifdef HORN_PWM_EN
  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0] duty;
  logic       pwm_q, pwm_d;

  // Offset-binary duty: silence sits at 50%
  always_comb begin
    duty      = {~sample_q[15], sample_q[14:8]};
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_d     = (pwm_cnt_q < duty);
  end

  always_ff @(posedge clk_noise or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_horn_tone_gen.sv
// Self-checking bench for horn_tone_gen: directed table, corner sequences and
// randomized gate/pitch traffic against a behavioural envelope model.
module tb_horn_tone_gen;

  localparam int ENV  = 4;
  localparam int ATK  = 'h2000;
  localparam int REL  = 'h4000;
  localparam int AMAX = 'h7FFF;
`ifdef HORN_PWM_EN
  localparam bit PWM_ON = 1'b1;
`else
  localparam bit PWM_ON = 1'b0;
`endif

  logic               clk_noise = 1'b0;
  logic               rst_n     = 1'b1;
  logic [21:0]        note_div  = '0;
  logic signed [15:0] sample_out;
  logic               tone_active;
  logic               pwm_out;

  int errors = 0;
  int checks = 0;

  horn_tone_gen #(
    .AMP_MAX (15'h7FFF),
    .ATK_STEP(15'h2000),
    .REL_STEP(15'h4000),
    .ENV_TICK(ENV)
  ) dut (
    .clk_noise  (clk_noise),
    .rst_n      (rst_n),
    .note_div   (note_div),
    .sample_out (sample_out),
    .tone_active(tone_active),
    .pwm_out    (pwm_out)
  );

  always #5 clk_noise = ~clk_noise;

  // Behavioural model: envelope level, tone half-period timer, output regs
  int m_env;   // 0 idle, 1 attack, 2 sustain, 3 release
  int m_amp, m_div, m_cnt, m_phase, m_tick;
  int m_sample, m_active, m_pcnt, m_pwm;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_env = 0; m_amp = 0; m_div = 0; m_cnt = 0; m_phase = 0; m_tick = 0;
    m_sample = 0; m_active = 0; m_pcnt = 0; m_pwm = 0;
  endtask

  task automatic model_step(input int nd);
    int env, amp, div, cnt, ph;
    bit gate, tick;
    gate = (nd != 0);
    tick = (m_tick == ENV - 1);
    env = m_env; amp = m_amp; div = m_div; cnt = m_cnt; ph = m_phase;
    if (PWM_ON) m_pwm = (m_pcnt < (m_sample + 32768) / 256);
    m_pcnt   = (m_pcnt + 1) % 256;
    m_sample = m_phase ? m_amp : -m_amp;
    m_active = (m_env != 0);
    if (m_env == 0) begin
      cnt = 0; ph = 0;
      if (gate) div = nd;
    end else if (m_cnt + 1 == m_div) begin
      ph = 1 - m_phase; cnt = 0;
      if (gate) div = nd;
    end else begin
      cnt = m_cnt + 1;
    end
    case (m_env)
      0: begin amp = 0; if (gate) env = 1; end
      1: if (!gate) env = 3;
         else if (tick) begin
           amp = (m_amp + ATK >= AMAX) ? AMAX : m_amp + ATK;
           if (amp == AMAX) env = 2;
         end
      2: begin amp = AMAX; if (!gate) env = 3; end
      default: if (gate) env = 1;
         else if (tick) begin
           amp = (m_amp - REL <= 0) ? 0 : m_amp - REL;
           if (amp == 0) env = 0;
         end
    endcase
    m_env = env; m_amp = amp; m_div = div; m_cnt = cnt; m_phase = ph;
    m_tick = (m_tick + 1) % ENV;
  endtask

  task automatic cyc();
    @(posedge clk_noise);
    if (!rst_n) model_reset();
    else model_step(int'(note_div));
    #1;
    chk("sample_vs_model", int'(sample_out), m_sample);
    chk("active_vs_model", int'(tone_active), m_active);
    chk("pwm_vs_model", int'(pwm_out), m_pwm);
  endtask

  function automatic int abs_s();
    int a;
    a = int'(sample_out);
    return (a < 0) ? -a : a;
  endfunction

  typedef struct {
    int nd;
    int cycles;
    bit hold;
    int exp_abs;
    int exp_act;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int q[$];
    int exp_seq[4];
    int ch[$];
    bit sg[80];
    bit found, p, s_prev, s_now;
    int last, hi, a;

    tbl[0] = '{nd: 0,  cycles: 5000, hold: 1'b1, exp_abs: 0,      exp_act: 0};
    tbl[1] = '{nd: 10, cycles: 40,   hold: 1'b0, exp_abs: 'h7FFF, exp_act: 1};
    tbl[2] = '{nd: 0,  cycles: 40,   hold: 1'b0, exp_abs: 0,      exp_act: 0};
    tbl[3] = '{nd: 3,  cycles: 40,   hold: 1'b0, exp_abs: 'h7FFF, exp_act: 1};
    tbl[4] = '{nd: 1,  cycles: 40,   hold: 1'b0, exp_abs: 'h7FFF, exp_act: 1};
    tbl[5] = '{nd: 0,  cycles: 40,   hold: 1'b0, exp_abs: 0,      exp_act: 0};
    exp_seq = '{'h2000, 'h4000, 'h6000, 'h7FFF};

    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_sample", int'(sample_out), 0);
    chk("reset_active", int'(tone_active), 0);
    chk("reset_pwm", int'(pwm_out), 0);
    repeat (3) cyc();
    rst_n = 1'b1;

    // Directed table
    for (int k = 0; k < 6; k++) begin
      note_div = 22'(tbl[k].nd);
      for (int c = 0; c < tbl[k].cycles; c++) begin
        cyc();
        if (tbl[k].hold) begin
          chk("idle_hold_sample", int'(sample_out), 0);
          chk("idle_hold_active", int'(tone_active), 0);
        end
      end
      chk($sformatf("tbl%0d_abs", k), abs_s(), tbl[k].exp_abs);
      chk($sformatf("tbl%0d_active", k), int'(tone_active), tbl[k].exp_act);
    end

    // Asynchronous reset in the middle of a tone
    note_div = 22'd10;
    repeat (30) cyc();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_sample", int'(sample_out), 0);
    chk("async_rst_active", int'(tone_active), 0);
    chk("async_rst_pwm", int'(pwm_out), 0);
    repeat (2) cyc();
    rst_n = 1'b1;

    // Attack from reset: tone_active latency and amplitude staircase
    cyc();
    chk("active_lat_edge1", int'(tone_active), 0);
    cyc();
    chk("active_lat_edge2", int'(tone_active), 1);
    last = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      a = abs_s();
      if (a != last) begin q.push_back(a); last = a; end
    end
    chk("attack_steps_count", q.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("attack_step%0d", k), (k < q.size()) ? q[k] : -1, exp_seq[k]);

    // Pitch change 10->25 mid half-period
    found = 1'b0;
    s_prev = sample_out < 0;
    for (int c = 0; c < 30 && !found; c++) begin
      cyc();
      s_now = sample_out < 0;
      if (s_now != s_prev) found = 1'b1;
      s_prev = s_now;
    end
    chk("pitch_sync_found", int'(found), 1);
    for (int i = 0; i < 80; i++) begin
      if (i == 4) note_div = 22'd25;
      cyc();
      sg[i] = sample_out < 0;
    end
    p = s_prev;
    for (int i = 0; i < 80; i++) begin
      if (sg[i] != p) ch.push_back(i);
      p = sg[i];
    end
    chk("pitch_edges_ge3", int'(ch.size() >= 3), 1);
    if (ch.size() >= 3) begin
      chk("halfperiod_old", ch[0] + 1, 10);
      chk("halfperiod_new1", ch[1] - ch[0], 25);
      chk("halfperiod_new2", ch[2] - ch[1], 25);
    end

    // Release then re-key: attack resumes from the released level
    note_div = 22'd0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      cyc();
      if (abs_s() == 'h3FFF) found = 1'b1;
    end
    chk("release_reaches_3fff", int'(found), 1);
    note_div = 22'd10;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      cyc();
      if (abs_s() != 'h3FFF) found = 1'b1;
    end
    chk("rekey_step_seen", int'(found), 1);
    chk("rekey_amp", abs_s(), 'h5FFF);
    chk("rekey_active", int'(tone_active), 1);

    // Release to idle
    note_div = 22'd0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      cyc();
      if (!tone_active) found = 1'b1;
    end
    chk("release_to_idle", int'(found), 1);
    chk("idle_sample_zero", int'(sample_out), 0);

    // Single-cycle gate pulse still passes through the envelope
    note_div = 22'd5;
    cyc();
    note_div = 22'd0;
    found = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (tone_active) found = 1'b1;
    end
    chk("pulse_active_seen", int'(found), 1);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      cyc();
      if (!tone_active) found = 1'b1;
    end
    chk("pulse_back_idle", int'(found), 1);

    // PWM duty at full positive amplitude and at silence
    note_div = 22'd600;
    found = 1'b0;
    for (int c = 0; c < 1400 && !found; c++) begin
      cyc();
      if (int'(sample_out) == 'h7FFF) found = 1'b1;
    end
    chk("pwm_full_found", int'(found), 1);
    cyc();
    hi = 0;
    for (int c = 0; c < 256; c++) begin
      cyc();
      hi += int'(pwm_out);
    end
    chk("pwm_full_duty", hi, PWM_ON ? 255 : 0);
    note_div = 22'd0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      cyc();
      if (!tone_active) found = 1'b1;
    end
    chk("pwm_silence_idle", int'(found), 1);
    repeat (2) cyc();
    hi = 0;
    for (int c = 0; c < 256; c++) begin
      cyc();
      hi += int'(pwm_out);
    end
    chk("pwm_silence_duty", hi, PWM_ON ? 128 : 0);

    // Randomized gate/pitch traffic
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 9) < 3) note_div = 22'd0;
      else note_div = 22'($urandom_range(1, 30));
      repeat ($urandom_range(1, 20)) cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
